// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel switch debouncer with run-time late/early filtering and rise/fall pulses
module debouncer_multi #(
  parameter int N_CH = 4,
  parameter int STABLE_TICKS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i_signal,
  input  logic              i_tick10ms,
  input  logic              i_mode,
  output logic [N_CH-1:0]   o_out,
  output logic [N_CH-1:0]   o_rise,
  output logic [N_CH-1:0]   o_fall,
  output logic [N_CH-1:0]   o_busy,
  output logic [3*N_CH-1:0] o_state
);
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  typedef enum logic [2:0] {LOW, ARM_HIGH, HIGH, ARM_LOW, LOCK_HIGH, LOCK_LOW} state_t;
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [1:0] sync;
    logic s, last, rise, fall, rise_n, fall_n;
    state_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    assign s = sync[1];
    assign last = cnt == CNT_W'(STABLE_TICKS - 1);
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync <= '0;
        st   <= LOW;
        cnt  <= '0;
        rise <= 1'b0;
        fall <= 1'b0;
      end else begin
        sync <= {sync[0], i_signal[k]};
        st   <= st_n;
        cnt  <= cnt_n;
        rise <= rise_n;
        fall <= fall_n;
      end
    end
    // Mode is only looked at when leaving a stable state; ARM/LOCK finish as entered
    always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      rise_n = 1'b0;
      fall_n = 1'b0;
      case (st)
        LOW: if (s) begin
          st_n   = i_mode ? LOCK_HIGH : ARM_HIGH;
          cnt_n  = '0;
          rise_n = i_mode;
        end
        ARM_HIGH: if (!s) begin
          st_n  = LOW;
          cnt_n = '0;
        end else if (i_tick10ms) begin
          st_n   = last ? HIGH : ARM_HIGH;
          cnt_n  = last ? '0 : cnt + 1'b1;
          rise_n = last;
        end
        LOCK_HIGH: if (i_tick10ms) begin
          st_n  = last ? HIGH : LOCK_HIGH;
          cnt_n = last ? '0 : cnt + 1'b1;
        end
        HIGH: if (!s) begin
          st_n   = i_mode ? LOCK_LOW : ARM_LOW;
          cnt_n  = '0;
          fall_n = i_mode;
        end
        ARM_LOW: if (s) begin
          st_n  = HIGH;
          cnt_n = '0;
        end else if (i_tick10ms) begin
          st_n   = last ? LOW : ARM_LOW;
          cnt_n  = last ? '0 : cnt + 1'b1;
          fall_n = last;
        end
        LOCK_LOW: if (i_tick10ms) begin
          st_n  = last ? LOW : LOCK_LOW;
          cnt_n = last ? '0 : cnt + 1'b1;
        end
        default: begin
          st_n  = LOW;
          cnt_n = '0;
        end
      endcase
    end
    assign o_out[k]          = st inside {HIGH, ARM_LOW, LOCK_HIGH};
    assign o_busy[k]         = st inside {ARM_HIGH, ARM_LOW, LOCK_HIGH, LOCK_LOW};
    assign o_rise[k]         = rise;
    assign o_fall[k]         = fall;
    assign o_state[3*k +: 3] = st;
  end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed stimulus with an event scoreboard checked by an independent pulse monitor
module tb_debouncer_multi;
  logic clk = 0, rst = 1, tick = 0, mode = 0;
  logic [1:0] sig = '0;
  logic [1:0] o_out, o_rise, o_fall, o_busy;
  logic [5:0] o_state;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {int ch; bit rise; int e;} ev_t;
  ev_t sb[$];
  ev_t ev;

  debouncer_multi #(.N_CH(2), .STABLE_TICKS(3)) dut (
    .clk(clk), .rst(rst), .i_signal(sig), .i_tick10ms(tick), .i_mode(mode),
    .o_out(o_out), .o_rise(o_rise), .o_fall(o_fall), .o_busy(o_busy), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // cyc = index of the last rising edge; tick is consumed on edges that are multiples of 5
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    tick = (cyc % 5 == 4);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic at(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_ev(input int ch, input bit rise, input int e);
    sb.push_back('{ch, rise, e});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        if (o_rise[c] | o_fall[c]) begin
          chk($sformatf("rise_and_fall_ch%0d", c), int'(o_rise[c] & o_fall[c]), 0);
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_pulse: ch%0d rise=%0d fall=%0d at cycle %0d, none required", c, o_rise[c], o_fall[c], cyc);
          end else begin
            ev = sb.pop_front();
            checks++;
            if (ev.ch != c || ev.rise != o_rise[c] || ev.e != cyc) begin
              fails++;
              $display("FAIL event: got ch%0d rise=%0d cycle %0d, required ch%0d rise=%0d cycle %0d", c, o_rise[c], cyc, ev.ch, ev.rise, ev.e);
            end
          end
        end
      end
    end
  end

  initial begin
    #1 rst = 0;
    #1;
    chk("rst_out", o_out, 0);
    chk("rst_rise", o_rise, 0);
    chk("rst_fall", o_fall, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_state", o_state, 0);
    at(3); rst = 1;
    at(10); sig = 2'b11; expect_ev(1, 1, 25);
    at(12); sig[0] = 0;
    at(14); sig[0] = 1;
    at(16); chk("bounce_beats_tick", o_state[2:0], 0); sig[0] = 0;
    at(20); chk("glitch_state0", o_state[2:0], 0); chk("glitch_out0", o_out[0], 0);
    at(24); chk("arm_state1", o_state[5:3], 1); chk("arm_busy1", o_busy[1], 1); chk("arm_out1", o_out[1], 0);
    at(26); chk("late_out1", o_out[1], 1);
    at(30); sig[0] = 1; expect_ev(0, 1, 45);
    at(50); sig[0] = 0; expect_ev(0, 0, 70);
    at(51); sig[0] = 1;
    at(53); chk("arm_low_state0", o_state[2:0], 3); sig[0] = 0;
    at(54); chk("bounce_back_high", o_state[2:0], 2);
    at(69); chk("fall_pending_out0", o_out[0], 1);
    at(71); chk("fall_done_out0", o_out[0], 0);
    at(75); mode = 1;
    at(80); sig[0] = 1; expect_ev(0, 1, 83);
    at(82); sig[0] = 0;
    at(84); chk("early_out0", o_out[0], 1); chk("lock_state0", o_state[2:0], 4); chk("lock_busy0", o_busy[0], 1); sig[0] = 1;
    at(86); sig[0] = 0;
    at(88); sig[0] = 1;
    at(94); chk("lock_busy_late0", o_busy[0], 1);
    at(96); chk("lock_end_state0", o_state[2:0], 2); chk("lock_end_busy0", o_busy[0], 0);
    at(100); sig[0] = 0; expect_ev(0, 0, 103);
    at(116); chk("lock_low_end0", o_state[2:0], 0); mode = 0;
    at(120); sig[0] = 1; expect_ev(0, 1, 135);
    at(124); chk("mode_toggle_arm0", o_state[2:0], 1); mode = 1;
    at(134); chk("still_late_out0", o_out[0], 0);
    at(140); sig[0] = 0; expect_ev(0, 0, 143);
    at(144); chk("next_is_early0", o_state[2:0], 5);
    at(156); chk("early_low_state0", o_state[2:0], 0); mode = 0;
    at(160); sig[1] = 0; expect_ev(1, 0, 175);
    at(180); sig[1] = 1;
    at(186); chk("pre_rst_arm1", o_state[5:3], 1); rst = 0;
    #1;
    chk("midrst_out1", o_out[1], 0);
    chk("midrst_busy1", o_busy[1], 0);
    chk("midrst_state1", o_state[5:3], 0);
    at(190); rst = 1; expect_ev(1, 1, 205);
    at(204); chk("post_rst_busy1", o_busy[1], 1);
    at(206); chk("post_rst_out1", o_out[1], 1);
    at(215); chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/debouncer_multi.md
# debouncer_multi

Parametrised N-channel switch debouncer, the successor to the single-channel late debouncer. Each channel synchronises its raw input, filters it against a shared slow tick (nominally 10 ms), and drives a clean level plus one-cycle rise/fall pulses. A run-time mode selects late filtering (change only after the input has been stable) or early filtering (change at once, then lock out bounces). It sits between the board push-buttons/switches and the control logic.

## Interface
- N_CH, 4: number of independent channels (>=1)
- STABLE_TICKS, 4: number of i_tick10ms pulses for stability/lockout (>=1)
- CNT_W, $clog2(STABLE_TICKS+1): tick counter width (derived, not overridden)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- i_signal  in  N_CH  raw asynchronous inputs, one bit per channel
- i_tick10ms  in  1  one-clk-wide sampling tick, shared by all channels
- i_mode  in  1  0 = late mode, 1 = early mode
- o_out  out  N_CH  debounced level per channel
- o_rise  out  N_CH  one-clk pulse when o_out goes 0->1
- o_fall  out  N_CH  one-clk pulse when o_out goes 1->0
- o_busy  out  N_CH  1 while channel is in an ARM or LOCK state
- o_state  out  3*N_CH  per-channel FSM state, channel k at [3k+2:3k], debug only

## Operation
- Per channel: 2-FF synchroniser on i_signal[k] -> s; one FSM; one CNT_W counter. Channels are fully independent.
- States (encoding): LOW=0, ARM_HIGH=1, HIGH=2, ARM_LOW=3, LOCK_HIGH=4, LOCK_LOW=5. o_out=1 in HIGH, ARM_LOW, LOCK_HIGH; 0 otherwise.
- LOW: s=1 and i_mode=0 -> ARM_HIGH, cnt=0. s=1 and i_mode=1 -> LOCK_HIGH, cnt=0, o_rise pulse.
- ARM_HIGH (late): s=0 -> LOW, cnt=0 (bounce, no pulse). Else on tick: cnt==STABLE_TICKS-1 -> HIGH, o_rise pulse; otherwise cnt++.
- LOCK_HIGH (early): s ignored. On tick: cnt==STABLE_TICKS-1 -> HIGH; otherwise cnt++.
- HIGH, ARM_LOW, LOCK_LOW: exact mirror with s inverted, o_fall instead of o_rise.
- i_mode sampled only in LOW/HIGH; changes during ARM/LOCK take effect on the next departure from a stable state.
- Early mode, input still changed when lockout ends: HIGH sees s=0 next cycle and starts a new transition normally.
- Counter never exceeds STABLE_TICKS-1; no wrap possible.

## Timing
- Reset (rst=0, async): all states LOW, cnt=0, synchronisers 0, o_out=0, o_rise=0, o_fall=0, o_busy=0. Reset mid-transition aborts with no pulse.
- After rst release with i_signal held high: channel debounces normally and produces o_rise.
- Synchroniser latency: 2 clk from i_signal edge to s.
- Late mode: tick in the entry cycle (LOW->ARM) is not counted. o_out rises on the edge of the STABLE_TICKS-th counted tick, i.e. >= 2 + 1 + STABLE_TICKS tick periods worst case.
- Early mode: o_out changes 3 clk after the i_signal edge (2 sync + 1 FSM).
- o_rise/o_fall are registered, asserted in the same cycle o_out first shows the new value, for exactly 1 clk; never both high.
- Simultaneous s bounce and tick in ARM: bounce wins -> back to stable state, cnt=0.
- Tick held high for multiple clk counts once per clk (caller guarantees 1-clk pulses).

## Test plan
- N_CH=2, STABLE_TICKS=3, tick every 5 clk, late mode. Reset: all outputs 0 in the cycle after rst falls, before any clk edge.
- Late mode, ch0 glitches 1 for 2 clk twice, then low: o_out[0] stays 0, no o_rise, state returns to 0. Ch1 held 1: o_rise[1] exactly once, 1 clk wide, on the 3rd counted tick.
- Late mode, ch0 high then bounces 1-0-1 within 4 clk before settling low: single o_fall[0]; o_out[0]=0 after 3 stable ticks.
- Early mode, ch0 0->1 with 3 bounces inside lockout: o_out[0]=1 three clk after the edge, single o_rise, o_busy=1 for 3 ticks, then state 2.
- Toggle i_mode during ARM_HIGH: transition completes in late behaviour; next transition uses early behaviour.
- Assert rst during ARM_HIGH on ch1: o_out[1]=0 immediately, no pulse. After release with input high: fresh debounce, one o_rise.
